wr_sched_arbiter: RTL



---
 rtl/wr_sched_arbiter_if.sv | 67 ++++++
 rtl/wr_sched_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/wr_sched_arbiter_if.sv
// Signal bundle between wr_sched_arbiter, its two line-write requesters,
// the AXI AW/B channels and the 4-beat write-data manager.
interface wr_sched_arbiter_if;
    // Requester 0
    logic         req0_valid;
    logic [31:0]  req0_addr;
    logic [127:0] req0_wdata;
    logic [15:0]  req0_mask;
    logic         req0_ready;
    logic         req0_done;
    logic         req0_err;
    // Requester 1
    logic         req1_valid;
    logic [31:0]  req1_addr;
    logic [127:0] req1_wdata;
    logic [15:0]  req1_mask;
    logic         req1_ready;
    logic         req1_done;
    logic         req1_err;
    // AXI write address channel
    logic         awvalid;
    logic         awready;
    logic [31:0]  awaddr;
    logic [3:0]   awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    // AXI write response channel
    logic         bvalid;
    logic         bready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    // Write-data manager
    logic         wd_rq;
    logic [3:0]   wd_id;
    logic [127:0] wd_wdata;
    logic [15:0]  wd_mask;
    logic         wd_finish;

    // Scheduler side
    modport master (
        input  req0_valid, req0_addr, req0_wdata, req0_mask,
        output req0_ready, req0_done, req0_err,
        input  req1_valid, req1_addr, req1_wdata, req1_mask,
        output req1_ready, req1_done, req1_err,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        input  bvalid, bid, bresp,
        output bready,
        output wd_rq, wd_id, wd_wdata, wd_mask,
        input  wd_finish
    );

    // Environment side: requesters, interconnect and data manager
    modport slave (
        output req0_valid, req0_addr, req0_wdata, req0_mask,
        input  req0_ready, req0_done, req0_err,
        output req1_valid, req1_addr, req1_wdata, req1_mask,
        input  req1_ready, req1_done, req1_err,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        output bvalid, bid, bresp,
        input  bready,
        input  wd_rq, wd_id, wd_wdata, wd_mask,
        output wd_finish
    );
endinterface

// File: rtl/wr_sched_arbiter.sv
// Two-requester round-robin write scheduler: one AXI line write (AW, 4 W beats
// through the data manager, B) outstanding at a time, completion routed to the owner.
module wr_sched_arbiter #(
    parameter logic [3:0]  ID0      = 4'd0,
    parameter logic [3:0]  ID1      = 4'd1,
    parameter logic [15:0] BTIMEOUT = 16'd1024
) (
    input  logic               clk,
    input  logic               rst_n,
    wr_sched_arbiter_if.master sched_if
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t       state_q;
    logic         last_grant_q;
    logic         owner_q;
    logic [27:0]  addr_q;
    logic [127:0] wdata_q;
    logic [15:0]  mask_q;
    logic [3:0]   id_q;
    logic [15:0]  tcnt_q;
    logic [15:0]  tcnt_d;
    logic         awvalid_q;
    logic         wd_rq_q;
    logic         bready_q;
    logic         done0_q, done1_q;
    logic         err0_q, err1_q;

    logic         grant0, grant1;
    logic         b_hit;
    logic         timeout;
    logic         resp_err;
    logic         unused_bits;

    // With both valid, the requester that did not win last time goes first.
    always_comb begin
        grant0 = sched_if.req0_valid & (~sched_if.req1_valid | last_grant_q);
        grant1 = sched_if.req1_valid & (~sched_if.req0_valid | ~last_grant_q);
    end

    assign b_hit    = (state_q == RESP) & sched_if.bvalid & (sched_if.bid == id_q);
    assign timeout  = (state_q == RESP) & (BTIMEOUT != 16'd0) & (tcnt_q == BTIMEOUT);
    assign resp_err = b_hit ? sched_if.bresp[1] : 1'b1;
    assign tcnt_d   = tcnt_q + 16'd1;

    // Line offset bits are dropped on the address; bresp[0] carries no error.
    assign unused_bits = ^{sched_if.req0_addr[3:0], sched_if.req1_addr[3:0], sched_if.bresp[0]};

    assign sched_if.req0_ready = (state_q == IDLE) & grant0;
    assign sched_if.req1_ready = (state_q == IDLE) & grant1;
    assign sched_if.req0_done  = done0_q;
    assign sched_if.req0_err   = err0_q;
    assign sched_if.req1_done  = done1_q;
    assign sched_if.req1_err   = err1_q;

    assign sched_if.awvalid    = awvalid_q;
    assign sched_if.awaddr     = {addr_q, 4'b0000};
    assign sched_if.awid       = id_q;
    assign sched_if.awlen      = 8'd3;
    assign sched_if.awsize     = 3'd2;
    assign sched_if.awburst    = 2'b01;
    assign sched_if.bready     = bready_q;

    assign sched_if.wd_rq      = wd_rq_q;
    assign sched_if.wd_id      = id_q;
    assign sched_if.wd_wdata   = wdata_q;
    assign sched_if.wd_mask    = mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            id_q         <= '0;
            tcnt_q       <= '0;
            awvalid_q    <= 1'b0;
            wd_rq_q      <= 1'b0;
            bready_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            wd_rq_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant0 | grant1) begin
                        addr_q       <= grant1 ? sched_if.req1_addr[31:4] : sched_if.req0_addr[31:4];
                        wdata_q      <= grant1 ? sched_if.req1_wdata : sched_if.req0_wdata;
                        mask_q       <= grant1 ? sched_if.req1_mask : sched_if.req0_mask;
                        id_q         <= grant1 ? ID1 : ID0;
                        owner_q      <= grant1;
                        last_grant_q <= grant1;
                        awvalid_q    <= 1'b1;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    if (sched_if.awready) begin
                        awvalid_q <= 1'b0;
                        wd_rq_q   <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (sched_if.wd_finish) begin
                        bready_q <= 1'b1;
                        tcnt_q   <= '0;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // A matching B wins over a timeout landing in the same cycle.
                    if (b_hit || timeout) begin
                        done0_q  <= ~owner_q;
                        done1_q  <= owner_q;
                        err0_q   <= ~owner_q & resp_err;
                        err1_q   <= owner_q & resp_err;
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
